// File: rtl/neander_pkg.sv
// Shared types and constants for the Neander-X tile.
package neander_pkg;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_LOAD,
        ST_RUN
    } loader_state_t;

    localparam int RAM_DEPTH         = 256;
    localparam int DEFAULT_BOOT_WAIT = 1024;

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer with a configurable reset level.
module sync_ff #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {N{RST_VAL}};
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/ram_loader.sv
// Serial program loader: shifts host bytes into program RAM
// and holds the CPU in reset until the load is finished.
module ram_loader
    import neander_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BOOT_WAIT   = DEFAULT_BOOT_WAIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_sclk,
    input  logic       ld_mosi,
    input  logic       ld_cs_n,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_ovf
);

    localparam int CNT_W = $clog2(BOOT_WAIT + 1) + 1;
    localparam logic [7:0] ADDR_LAST = 8'(RAM_DEPTH - 1);

    logic sclk_s;
    logic mosi_s;
    logic csn_s;

    sync_ff #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ld_sclk),
        .q_o   (sclk_s)
    );

    sync_ff #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ld_mosi),
        .q_o   (mosi_s)
    );

    sync_ff #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ld_cs_n),
        .q_o   (csn_s)
    );

    loader_state_t state_q, state_d;

    logic             sclk_prev_q;
    logic             csn_prev_q;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             full_q, full_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic       sclk_rise;
    logic       csn_rise;
    logic       csn_fall;
    logic       load_entry;
    logic       bit_take;
    logic       byte_done;
    logic [7:0] byte_in;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;

    // Gating on the previous cs_n lets an 8th bit that lands
    // together with the cs_n rise still be written.
    assign bit_take   = (state_q == ST_LOAD) && sclk_rise && !csn_prev_q;
    assign byte_done  = bit_take && (bit_cnt_q == 3'd7);
    assign byte_in    = {shift_q[6:0], mosi_s};
    assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT: begin
                if (!csn_s) begin
                    state_d = ST_LOAD;
                end else if (boot_cnt_q == CNT_W'(BOOT_WAIT)) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (csn_rise) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (csn_fall) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        cpu_hold = (state_q != ST_RUN);
    end

    always_comb begin
        boot_cnt_d = boot_cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        full_d     = full_q;
        done_d     = done_q;
        ovf_d      = ovf_q;

        if (state_q == ST_WAIT) begin
            boot_cnt_d = boot_cnt_q + CNT_W'(1);
        end

        if (bit_take) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (byte_done) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                wdata_d = byte_in;
            end
        end

        // The address advances the cycle after the strobe and
        // parks on the last slot once it has been written.
        if (load_entry) begin
            bit_cnt_d = 3'd0;
            addr_d    = 8'd0;
            full_d    = 1'b0;
        end else if (we_q) begin
            if (addr_q == ADDR_LAST) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + 8'd1;
            end
        end

        if (state_q == ST_LOAD && state_d == ST_RUN) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
            boot_cnt_q  <= '0;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 3'd0;
            addr_q      <= 8'd0;
            wdata_q     <= 8'd0;
            we_q        <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
            boot_cnt_q  <= boot_cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            full_q      <= full_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;
    assign load_done = done_q;
    assign load_ovf  = ovf_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: host frames, overflow,
// reload, boot timeout and reset during a load.
`timescale 1ns/1ps
module tb_ram_loader;

    localparam int SS = 2;
    localparam int BW = 40;

    logic       clk;
    logic       rst_n;
    logic       ld_sclk;
    logic       ld_mosi;
    logic       ld_cs_n;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic       cpu_hold;
    logic       load_done;
    logic       load_ovf;

    int n_tests;
    int n_fail;

    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];

    ram_loader #(.SYNC_STAGES(SS), .BOOT_WAIT(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_sclk   (ld_sclk),
        .ld_mosi   (ld_mosi),
        .ld_cs_n   (ld_cs_n),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_ovf  (load_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic clr_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ld_mosi = b;
        repeat (3) @(negedge clk);
        ld_sclk = 1'b1;
        repeat (6) @(negedge clk);
        ld_sclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        ld_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        ld_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        ld_cs_n = 1'b1;
        ld_sclk = 1'b0;
        ld_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clr_log();
    endtask

    initial begin
        logic [7:0] exp_b;
        int         errs;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        ld_cs_n = 1'b1;
        ld_sclk = 1'b0;
        ld_mosi = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", load_done, 0);
        check("rst_ovf", load_ovf, 0);

        // boot timeout, no host
        @(negedge clk);
        rst_n = 1'b1;
        clr_log();
        repeat (BW) @(posedge clk);
        #1 check("boot_hold_bw", cpu_hold, 1);
        @(posedge clk);
        #1 check("boot_hold_bw1", cpu_hold, 0);
        repeat (5) @(negedge clk);
        check("boot_nwr", wa_q.size(), 0);
        check("boot_done", load_done, 0);

        // three-byte frame from WAIT
        reset_dut();
        start_frame();
        send_byte(8'h20);
        send_byte(8'h80);
        send_byte(8'hF0);
        end_frame();
        check("f3_nwr", wa_q.size(), 3);
        if (wa_q.size() == 3) begin
            check("f3_a0", wa_q[0], 8'h00);
            check("f3_d0", wd_q[0], 8'h20);
            check("f3_a1", wa_q[1], 8'h01);
            check("f3_d1", wd_q[1], 8'h80);
            check("f3_a2", wa_q[2], 8'h02);
            check("f3_d2", wd_q[2], 8'hF0);
        end
        check("f3_done", load_done, 1);
        check("f3_hold", cpu_hold, 0);

        // 12-bit frame: trailing nibble dropped
        reset_dut();
        start_frame();
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        end_frame();
        check("p12_nwr", wa_q.size(), 1);
        if (wa_q.size() >= 1) begin
            check("p12_a0", wa_q[0], 8'h00);
            check("p12_d0", wd_q[0], 8'hA5);
        end
        check("p12_hold", cpu_hold, 0);
        check("p12_done", load_done, 1);

        // 257-byte frame via reload from RUN
        clr_log();
        start_frame();
        for (int i = 0; i < 256; i++) begin
            exp_b = 8'(i) ^ 8'h5A;
            send_byte(exp_b);
        end
        check("ovf_pre", load_ovf, 0);
        check("full_nwr", wa_q.size(), 256);
        check("full_addr", ram_addr, 8'hFF);
        send_byte(8'hC3);
        check("ovf_set", load_ovf, 1);
        check("ovf_nwr", wa_q.size(), 256);
        end_frame();
        check("ovf_addr", ram_addr, 8'hFF);
        check("ovf_hold", cpu_hold, 0);
        errs = 0;
        for (int i = 0; i < wa_q.size(); i++) begin
            exp_b = 8'(i) ^ 8'h5A;
            if (wa_q[i] !== 8'(i) || wd_q[i] !== exp_b) begin
                errs++;
            end
        end
        check("fill_errs", errs, 0);

        // reload with one byte keeps the sticky overflow
        clr_log();
        start_frame();
        check("rl_hold_hi", cpu_hold, 1);
        send_byte(8'h33);
        end_frame();
        check("rl_nwr", wa_q.size(), 1);
        if (wa_q.size() >= 1) begin
            check("rl_a0", wa_q[0], 8'h00);
            check("rl_d0", wd_q[0], 8'h33);
        end
        check("rl_hold_lo", cpu_hold, 0);
        check("rl_ovf", load_ovf, 1);

        // reset in the middle of a byte
        clr_log();
        start_frame();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_we", ram_we, 0);
        check("mr_addr", ram_addr, 0);
        check("mr_wdata", ram_wdata, 0);
        check("mr_hold", cpu_hold, 1);
        check("mr_done", load_done, 0);
        check("mr_ovf", load_ovf, 0);
        ld_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("mr_wait_hold", cpu_hold, 1);
        check("mr_nwr", wa_q.size(), 0);
        repeat (BW) @(negedge clk);
        check("mr_boot_hold", cpu_hold, 0);
        check("mr_boot_done", load_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
